// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit -- multi-cycle sequencer for the K&S processor.
//
// Drives every data_path control input plus the RAM write strobe. It consumes
// the decoded instruction held in the IR and the four registered ALU flags.
// Instruction cycle: FETCH -> DECODE -> execute state(s) -> FETCH.
//
// Also contains package k_and_s_pkg, which defines the decoded-instruction
// type shared with data_path.
//
// Parameters:
//   BOV_SIGNED          1: BOV/BNOV test signed_overflow
//                       0: BOV/BNOV test unsigned_overflow
//
// Optional feature (compile-time macro CU_MEM_WAIT_EN):
//   When CU_MEM_WAIT_EN is defined, the module gains the input mem_ready.
//   FETCH, LOAD_2 and STORE_2 then hold while mem_ready=0. Their strobes
//   (ir_enable, write_reg_enable, ram_write_enable, pc_enable) fire only in
//   the cycle with mem_ready=1.
//   When CU_MEM_WAIT_EN is undefined, memory is treated as always ready.
//
// Ports:
//   clk                  in   clock, all state changes on posedge
//   rst_n                in   asynchronous active-low reset
//   mem_ready            in   memory ready (only with CU_MEM_WAIT_EN)
//   decoded_instruction  in   current IR decode
//   zero_op              in   registered zero flag
//   neg_op               in   registered negative flag
//   unsigned_overflow    in   registered unsigned overflow flag
//   signed_overflow      in   registered signed overflow flag
//   branch               out  PC loads mem_addr instead of PC+1
//   pc_enable            out  PC update strobe
//   ir_enable            out  IR load strobe
//   addr_sel             out  0: ram_addr=PC, 1: ram_addr=mem_addr
//   c_sel                out  0: bus_c=data_in, 1: bus_c=alu_out
//   operation            out  00 OR, 01 ADD, 10 SUB, 11 AND
//   write_reg_enable     out  register-file write strobe
//   flags_reg_enable     out  flag register load strobe
//   ram_write_enable     out  RAM write strobe
//   halt                 out  processor stopped
// ---------------------------------------------------------------------------

package k_and_s_pkg;

    // Five bits leave room for encodings the decoder does not recognise.
    // Those encodings execute as NOP.
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter bit BOV_SIGNED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef CU_MEM_WAIT_EN
    input  logic                    mem_ready,
`endif
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_LOAD_1  = 4'd2,
        S_LOAD_2  = 4'd3,
        S_STORE_1 = 4'd4,
        S_STORE_2 = 4'd5,
        S_MOVE    = 4'd6,
        S_ALU     = 4'd7,
        S_BRANCH  = 4'd8,
        S_NOP     = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    state_t state;
    state_t next_state;

    // Memory handshake. The memory-touching states advance and strobe only
    // when mem_ok is high. Without the wait feature, mem_ok is tied high.
    logic mem_ok;
`ifdef CU_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // Overflow flag used by BOV/BNOV, selected at elaboration time.
    logic ovf;
    assign ovf = BOV_SIGNED ? signed_overflow : unsigned_overflow;

    // Branch condition. The flags are the registered values, so an ALU
    // instruction immediately before the branch is already reflected here.
    logic branch_taken;
    always_comb begin
        branch_taken = 1'b0;
        case (decoded_instruction)
            I_BRANCH: branch_taken = 1'b1;
            I_BZERO:  branch_taken = zero_op;
            I_BNZERO: branch_taken = ~zero_op;
            I_BNEG:   branch_taken = neg_op;
            I_BNNEG:  branch_taken = ~neg_op;
            I_BOV:    branch_taken = ovf;
            I_BNOV:   branch_taken = ~ovf;
            default:  branch_taken = 1'b0;
        endcase
    end

    // ALU opcode for the ALU state. MOVE does not use this; it forces OR (a|a).
    logic [1:0] alu_op;
    always_comb begin
        alu_op = OP_OR;
        case (decoded_instruction)
            I_ADD:   alu_op = OP_ADD;
            I_SUB:   alu_op = OP_SUB;
            I_AND:   alu_op = OP_AND;
            default: alu_op = OP_OR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state       = state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_OR;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (state)
            S_FETCH: begin
                addr_sel  = 1'b0;
                ir_enable = mem_ok;
                if (mem_ok) begin
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:   next_state = S_LOAD_1;
                    I_STORE:  next_state = S_STORE_1;
                    I_MOVE:   next_state = S_MOVE;
                    I_ADD,
                    I_SUB,
                    I_AND,
                    I_OR:     next_state = S_ALU;
                    I_BRANCH,
                    I_BZERO,
                    I_BNZERO,
                    I_BNEG,
                    I_BNNEG,
                    I_BOV,
                    I_BNOV:   next_state = S_BRANCH;
                    I_HALT:   next_state = S_HALT;
                    default:  next_state = S_NOP;
                endcase
            end

            // The first cycle puts mem_addr on the RAM address. The read data
            // is captured in the second cycle.
            S_LOAD_1: begin
                addr_sel   = 1'b1;
                next_state = S_LOAD_2;
            end

            S_LOAD_2: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b0;
                write_reg_enable = mem_ok;
                pc_enable        = mem_ok;
                if (mem_ok) begin
                    next_state = S_FETCH;
                end
            end

            // Address setup precedes the write strobe by one cycle.
            S_STORE_1: begin
                addr_sel   = 1'b1;
                next_state = S_STORE_2;
            end

            S_STORE_2: begin
                addr_sel         = 1'b1;
                ram_write_enable = mem_ok;
                pc_enable        = mem_ok;
                if (mem_ok) begin
                    next_state = S_FETCH;
                end
            end

            // A register copy goes through the ALU as a|a. Flags are left
            // untouched.
            S_MOVE: begin
                operation        = OP_OR;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                pc_enable        = 1'b1;
                next_state       = S_FETCH;
            end

            S_ALU: begin
                operation        = alu_op;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                pc_enable        = 1'b1;
                next_state       = S_FETCH;
            end

            S_BRANCH: begin
                pc_enable  = 1'b1;
                branch     = branch_taken;
                next_state = S_FETCH;
            end

            S_NOP: begin
                pc_enable  = 1'b1;
                next_state = S_FETCH;
            end

            // Terminal state: only rst_n leaves it.
            S_HALT: begin
                halt       = 1'b1;
                next_state = S_HALT;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase

        // While reset is held, the state already reads FETCH. FETCH would
        // otherwise raise ir_enable, so every output is forced low here.
        if (!rst_n) begin
            branch           = 1'b0;
            pc_enable        = 1'b0;
            ir_enable        = 1'b0;
            addr_sel         = 1'b0;
            c_sel            = 1'b0;
            operation        = OP_OR;
            write_reg_enable = 1'b0;
            flags_reg_enable = 1'b0;
            ram_write_enable = 1'b0;
            halt             = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit -- self-checking bench for control_unit.
//
// Two instances share all inputs:
//   dut_s   BOV_SIGNED=1
//   dut_u   BOV_SIGNED=0
//
// A table of per-cycle records {instruction, flags, expected outputs} is
// replayed starting from reset release. Hand-written sequences then cover:
//   - reset in the middle of an instruction
//   - HALT
//   - memory wait, when CU_MEM_WAIT_EN is defined
//
// Packed output order:
//   {branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0],
//    write_reg_enable, flags_reg_enable, ram_write_enable, halt}
// ---------------------------------------------------------------------------

module tb_control_unit;
    import k_and_s_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT inputs ----------------
    decoded_instruction_type decoded_instruction = I_NOP;
    logic zero_op = 1'b0;
    logic neg_op = 1'b0;
    logic unsigned_overflow = 1'b0;
    logic signed_overflow = 1'b0;
`ifdef CU_MEM_WAIT_EN
    logic mem_ready = 1'b1;
`endif

    // ---------------- DUT outputs ----------------
    logic       branch_s, pc_enable_s, ir_enable_s, addr_sel_s, c_sel_s;
    logic [1:0] operation_s;
    logic       write_reg_enable_s, flags_reg_enable_s, ram_write_enable_s, halt_s;
    logic       branch_u, pc_enable_u, ir_enable_u, addr_sel_u, c_sel_u;
    logic [1:0] operation_u;
    logic       write_reg_enable_u, flags_reg_enable_u, ram_write_enable_u, halt_u;

    control_unit #(.BOV_SIGNED(1'b1)) dut_s (
        .clk                 (clk),
        .rst_n               (rst_n),
`ifdef CU_MEM_WAIT_EN
        .mem_ready           (mem_ready),
`endif
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch_s),
        .pc_enable           (pc_enable_s),
        .ir_enable           (ir_enable_s),
        .addr_sel            (addr_sel_s),
        .c_sel               (c_sel_s),
        .operation           (operation_s),
        .write_reg_enable    (write_reg_enable_s),
        .flags_reg_enable    (flags_reg_enable_s),
        .ram_write_enable    (ram_write_enable_s),
        .halt                (halt_s)
    );

    control_unit #(.BOV_SIGNED(1'b0)) dut_u (
        .clk                 (clk),
        .rst_n               (rst_n),
`ifdef CU_MEM_WAIT_EN
        .mem_ready           (mem_ready),
`endif
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch_u),
        .pc_enable           (pc_enable_u),
        .ir_enable           (ir_enable_u),
        .addr_sel            (addr_sel_u),
        .c_sel               (c_sel_u),
        .operation           (operation_u),
        .write_reg_enable    (write_reg_enable_u),
        .flags_reg_enable    (flags_reg_enable_u),
        .ram_write_enable    (ram_write_enable_u),
        .halt                (halt_u)
    );

    logic [10:0] out_s, out_u;
    assign out_s = {branch_s, pc_enable_s, ir_enable_s, addr_sel_s, c_sel_s, operation_s,
                    write_reg_enable_s, flags_reg_enable_s, ram_write_enable_s, halt_s};
    assign out_u = {branch_u, pc_enable_u, ir_enable_u, addr_sel_u, c_sel_u, operation_u,
                    write_reg_enable_u, flags_reg_enable_u, ram_write_enable_u, halt_u};

    // ---------------- expected-value helpers ----------------
    function automatic logic [10:0] mk(input logic br, input logic pc, input logic ir,
                                       input logic as, input logic cs, input logic [1:0] op,
                                       input logic wr, input logic fl, input logic rw,
                                       input logic ht);
        return {br, pc, ir, as, cs, op, wr, fl, rw, ht};
    endfunction

    // pc_enable | write_reg_enable | ram_write_enable
    localparam logic [10:0] STROBE_MASK = 11'b010_0000_1010;

    logic [10:0] e_fetch, e_idle, e_ld1, e_ld2, e_st1, e_st2, e_move;
    logic [10:0] e_add, e_sub, e_and, e_or, e_pc, e_taken, e_halt;

    typedef struct packed {
        logic [4:0]  ins;
        logic [3:0]  fl;    // {zero_op, neg_op, unsigned_overflow, signed_overflow}
        logic [10:0] exp_s;
        logic [10:0] exp_u;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int idx,
                         input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s idx=%0d got=%b expected=%b", name, idx, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [4:0] ins, input logic [3:0] fl,
                        input logic [10:0] es, input logic [10:0] eu);
        vec_t v;
        v.ins = ins;
        v.fl = fl;
        v.exp_s = es;
        v.exp_u = eu;
        vecs.push_back(v);
    endtask

    task automatic push3(input logic [4:0] ins, input logic [3:0] fl,
                         input logic [10:0] es, input logic [10:0] eu);
        push(ins, fl, e_fetch, e_fetch);
        push(ins, fl, e_idle, e_idle);
        push(ins, fl, es, eu);
    endtask

    task automatic push4(input logic [4:0] ins, input logic [10:0] e1, input logic [10:0] e2);
        push(ins, 4'b0000, e_fetch, e_fetch);
        push(ins, 4'b0000, e_idle, e_idle);
        push(ins, 4'b0000, e1, e1);
        push(ins, 4'b0000, e2, e2);
    endtask

    // Drive one cycle at the negedge, then sample both instances 1 ns later.
    task automatic step(input string name, input int idx, input decoded_instruction_type ins,
                        input logic [10:0] es, input logic [10:0] eu);
        @(negedge clk);
        decoded_instruction = ins;
        #1;
        check({name, "_s"}, idx, out_s, es);
        check({name, "_u"}, idx, out_u, eu);
    endtask

    // Assert reset at a negedge and check that all outputs are low.
    // Release reset just after the following posedge, so the next negedge
    // sees the first FETCH cycle.
    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check({name, "_s"}, 0, out_s, 11'b0);
        check({name, "_u"}, 0, out_u, 11'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d passes=%0d", checks, passes);
        $fatal(1, "timeout");
    end

    // ---------------- main test ----------------
    initial begin
        logic [10:0] prev_s;

        e_fetch = mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        e_idle  = 11'b0;
        e_ld1   = mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        e_ld2   = mk(0, 1, 0, 1, 0, 2'b00, 1, 0, 0, 0);
        e_st1   = mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        e_st2   = mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 1, 0);
        e_move  = mk(0, 1, 0, 0, 1, 2'b00, 1, 0, 0, 0);
        e_add   = mk(0, 1, 0, 0, 1, 2'b01, 1, 1, 0, 0);
        e_sub   = mk(0, 1, 0, 0, 1, 2'b10, 1, 1, 0, 0);
        e_and   = mk(0, 1, 0, 0, 1, 2'b11, 1, 1, 0, 0);
        e_or    = mk(0, 1, 0, 0, 1, 2'b00, 1, 1, 0, 0);
        e_pc    = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        e_taken = mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        e_halt  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);

        // Instruction table; flags are {zero, neg, uovf, sovf}.
        push3(I_ADD,    4'b0000, e_add,   e_add);
        push3(I_SUB,    4'b0000, e_sub,   e_sub);
        push3(I_AND,    4'b0000, e_and,   e_and);
        push3(I_OR,     4'b0000, e_or,    e_or);
        push3(I_MOVE,   4'b1111, e_move,  e_move);
        push4(I_LOAD,   e_ld1, e_ld2);
        push4(I_STORE,  e_st1, e_st2);
        push3(I_NOP,    4'b0000, e_pc,    e_pc);
        push3(5'd20,    4'b1111, e_pc,    e_pc);      // unrecognised encoding
        push3(I_BRANCH, 4'b0000, e_taken, e_taken);
        push3(I_BZERO,  4'b1000, e_taken, e_taken);
        push3(I_BZERO,  4'b0111, e_pc,    e_pc);
        push3(I_BNZERO, 4'b0000, e_taken, e_taken);
        push3(I_BNZERO, 4'b1000, e_pc,    e_pc);
        push3(I_BNEG,   4'b0100, e_taken, e_taken);
        push3(I_BNEG,   4'b1011, e_pc,    e_pc);
        push3(I_BNNEG,  4'b0000, e_taken, e_taken);
        push3(I_BNNEG,  4'b0100, e_pc,    e_pc);
        push3(I_BOV,    4'b0001, e_taken, e_pc);      // signed ovf only
        push3(I_BOV,    4'b0010, e_pc,    e_taken);   // unsigned ovf only
        push3(I_BNOV,   4'b0001, e_pc,    e_taken);
        push3(I_BNOV,   4'b0000, e_taken, e_taken);

        // Reset state, then the table starting at the first FETCH.
        do_reset("reset_idle");
        prev_s = 11'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            decoded_instruction = decoded_instruction_type'(vecs[i].ins);
            {zero_op, neg_op, unsigned_overflow, signed_overflow} = vecs[i].fl;
            #1;
            check("vec_s", i, out_s, vecs[i].exp_s);
            check("vec_u", i, out_u, vecs[i].exp_u);
            check("no_double_strobe", i, prev_s & out_s & STROBE_MASK, 11'b0);
            prev_s = out_s;
        end

        // Reset in the middle of a LOAD. LOAD_2 must never be issued
        // after reset is released.
        step("mid_fetch", 0, I_LOAD, e_fetch, e_fetch);
        step("mid_decode", 0, I_LOAD, e_idle, e_idle);
        step("mid_load1", 0, I_LOAD, e_ld1, e_ld1);
        do_reset("mid_reset");
        step("mid_after_fetch", 0, I_LOAD, e_fetch, e_fetch);
        step("mid_after_decode", 0, I_LOAD, e_idle, e_idle);
        step("mid_after_load1", 0, I_LOAD, e_ld1, e_ld1);
        step("mid_after_load2", 0, I_LOAD, e_ld2, e_ld2);

        // HALT: terminal for 100 cycles, then left only through rst_n.
        step("halt_fetch", 0, I_HALT, e_fetch, e_fetch);
        step("halt_decode", 0, I_HALT, e_idle, e_idle);
        for (int c = 0; c < 100; c++) begin
            step("halt_hold", c, (c % 2 == 0) ? I_NOP : I_ADD, e_halt, e_halt);
        end
        do_reset("halt_reset");
        step("halt_exit_fetch", 0, I_NOP, e_fetch, e_fetch);
        step("halt_exit_decode", 0, I_NOP, e_idle, e_idle);
        step("halt_exit_nop", 0, I_NOP, e_pc, e_pc);

`ifdef CU_MEM_WAIT_EN
        // FETCH stalls while mem_ready=0. ir_enable fires exactly once.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            decoded_instruction = I_STORE;
            #1;
            check("wait_fetch_s", c, out_s, e_idle);
            check("wait_fetch_u", c, out_u, e_idle);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("wait_fetch_go", 0, out_s, e_fetch);
        step("wait_decode", 0, I_STORE, e_idle, e_idle);
        step("wait_store1", 0, I_STORE, e_st1, e_st1);
        // STORE_2 stalls: address held, no write or PC strobe.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check("wait_store2_hold", c, out_s, e_st1);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("wait_store2_go", 0, out_s, e_st2);
        step("wait_next_fetch", 0, I_NOP, e_fetch, e_fetch);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
